// File: rtl/pipe_chain_pkg.sv
// Shared defaults and helpers for the elastic pipeline-register chain.
package pipe_chain_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One stage of the chain: a valid bit plus a payload register.
module pipe_slot
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic             kill,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid_nxt,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             take;

    // A held stage keeps its payload but drops validity when killed;
    // otherwise it takes a valid, unheld source or becomes a bubble.
    always_comb begin
        take    = ~hold & load & src_valid;
        valid_d = take;
        data_d  = data_q;
        if (hold) begin
            valid_d = valid_q & ~kill;
        end
        if (take) begin
            data_d = src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_nxt = valid_d;
    assign valid     = valid_q;
    assign data      = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Elastic chain of pipeline registers with per-stage stall, flush and
// output backpressure; stage 0 is youngest, stage DEPTH-1 drives the output.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = occ_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [CW-1:0]          occupancy
);

    logic [DEPTH-1:0] veff;
    logic [DEPTH:0]   hold;
    logic [DEPTH-1:0] valid_nxt;
    logic [CW-1:0]    occupancy_q;
    logic [CW-1:0]    occupancy_d;

    assign veff = stage_valid & ~flush;

    // Backpressure ripples from the consumer toward stage 0; a stall holds
    // its stage even when empty, which also blocks everything upstream.
    always_comb begin
        hold[DEPTH] = ~out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hold[i] = stall[i] | (veff[i] & hold[i+1]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             src_valid;
        logic             src_load;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_load  = 1'b1;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = veff[i-1];
            assign src_load  = ~hold[i-1];
            assign src_data  = stage_data[(i-1)*WIDTH +: WIDTH];
        end

        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .hold     (hold[i]),
            .load     (src_load),
            .kill     (flush[i]),
            .src_valid(src_valid),
            .src_data (src_data),
            .valid_nxt(valid_nxt[i]),
            .valid    (stage_valid[i]),
            .data     (stage_data[i*WIDTH +: WIDTH])
        );
    end

    // Occupancy is registered from the next-state valid bits so it always
    // matches the stage_valid vector of the same cycle.
    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + CW'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;
    assign in_ready  = ~hold[0] & ~reset;
    assign out_valid = veff[DEPTH-1] & ~reset;
    assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (DEPTH=4, WIDTH=32): vector table plus
// hand-written backpressure and mid-stream reset sequences.
module tb_pipe_chain;

    localparam int W = 32;
    localparam int D = 4;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [D-1:0]   stall;
    logic [D-1:0]   flush;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [2:0]     occupancy;

    pipe_chain #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           iv;
        logic [W-1:0]   id;
        logic           ordy;
        logic [D-1:0]   st;
        logic [D-1:0]   fl;
        logic           e_ir;
        logic           e_ov;
        logic [W-1:0]   e_od;
        logic [D-1:0]   e_sv;
        logic [2:0]     e_occ;
        logic [D*W-1:0] e_sd;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [W-1:0] A = 32'hA1;
    localparam logic [W-1:0] B = 32'hB2;
    localparam logic [W-1:0] C = 32'hC3;
    localparam logic [W-1:0] E = 32'hE5;
    localparam logic [W-1:0] DD = 32'hD4;
    localparam logic [W-1:0] Z = 32'h0;

    function automatic logic [D*W-1:0] sd(input logic [W-1:0] d3, input logic [W-1:0] d2,
                                          input logic [W-1:0] d1, input logic [W-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic rst, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic [D-1:0] st, input logic [D-1:0] fl,
                       input logic e_ir, input logic e_ov, input logic [W-1:0] e_od,
                       input logic [D-1:0] e_sv, input logic [2:0] e_occ,
                       input logic [D*W-1:0] e_sd);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.st = st; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_sv = e_sv; v.e_occ = e_occ;
        v.e_sd = e_sd;
        tbl.push_back(v);
    endtask

    // From empty, push A,B,C,D with the consumer ready: ends with stage3=A..stage0=D.
    task automatic add_fill();
        add(1'b0, 1'b1, A,  1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0001, 3'd1, sd(Z, Z, Z, A));
        add(1'b0, 1'b1, B,  1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0011, 3'd2, sd(Z, Z, A, B));
        add(1'b0, 1'b1, C,  1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0111, 3'd3, sd(Z, A, B, C));
        add(1'b0, 1'b1, DD, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b1111, 3'd4, sd(A, B, C, DD));
    endtask

    task automatic chk(input string nm, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] got[$];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        stall     = '0;
        flush     = '0;

        // Reset, then streaming 0x11/0x22/0x33.
        add(1'b1, 1'b1, Z, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, Z, 4'b0000, 3'd0, '0);
        add(1'b0, 1'b1, 32'h11, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0001, 3'd1, sd(Z, Z, Z, 32'h11));
        add(1'b0, 1'b1, 32'h22, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0011, 3'd2, sd(Z, Z, 32'h11, 32'h22));
        add(1'b0, 1'b1, 32'h33, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0111, 3'd3, sd(Z, 32'h11, 32'h22, 32'h33));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b1110, 3'd3, sd(32'h11, 32'h22, 32'h33, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, 32'h11, 4'b1100, 3'd2, sd(32'h22, 32'h33, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, 32'h22, 4'b1000, 3'd1, sd(32'h33, Z, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, 32'h33, 4'b0000, 3'd0, '0);

        // Load-use stall on stage 1 while E is offered.
        add_fill();
        add(1'b0, 1'b1, E, 1'b1, 4'b0010, 4'b0, 1'b0, 1'b1, A, 4'b1011, 3'd3, sd(B, Z, C, DD));
        add(1'b0, 1'b1, E, 1'b1, 4'b0000, 4'b0, 1'b1, 1'b1, B, 4'b0111, 3'd3, sd(Z, C, DD, E));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b1110, 3'd3, sd(C, DD, E, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, C, 4'b1100, 3'd2, sd(DD, E, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, DD, 4'b1000, 3'd1, sd(E, Z, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, E, 4'b0000, 3'd0, '0);

        // Flush of stages 0 and 1 with E accepted the same cycle.
        add_fill();
        add(1'b0, 1'b1, E, 1'b1, 4'b0, 4'b0011, 1'b1, 1'b1, A, 4'b1001, 3'd2, sd(B, Z, Z, E));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, B, 4'b0010, 3'd1, sd(Z, Z, E, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0100, 3'd1, sd(Z, E, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b1000, 3'd1, sd(E, Z, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, E, 4'b0000, 3'd0, '0);

        // Stall and flush on the same stage.
        add_fill();
        add(1'b0, 1'b0, Z, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, A, 4'b0011, 3'd2, sd(Z, Z, C, DD));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b0110, 3'd2, sd(Z, C, DD, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, Z, 4'b1100, 3'd2, sd(C, DD, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, C, 4'b1000, 3'd1, sd(DD, Z, Z, Z));
        add(1'b0, 1'b0, Z, 1'b1, 4'b0, 4'b0, 1'b1, 1'b1, DD, 4'b0000, 3'd0, '0);

        @(posedge clk);
        #1;
        for (int r = 0; r < tbl.size(); r++) begin
            reset     = tbl[r].rst;
            in_valid  = tbl[r].iv;
            in_data   = tbl[r].id;
            out_ready = tbl[r].ordy;
            stall     = tbl[r].st;
            flush     = tbl[r].fl;
            @(negedge clk);
            chk($sformatf("r%0d in_ready", r), 128'(in_ready), 128'(tbl[r].e_ir));
            chk($sformatf("r%0d out_valid", r), 128'(out_valid), 128'(tbl[r].e_ov));
            if (tbl[r].e_ov)
                chk($sformatf("r%0d out_data", r), 128'(out_data), 128'(tbl[r].e_od));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d stage_valid", r), 128'(stage_valid), 128'(tbl[r].e_sv));
            chk($sformatf("r%0d occupancy", r), 128'(occupancy), 128'(tbl[r].e_occ));
            for (int i = 0; i < D; i++) begin
                if (tbl[r].e_sv[i])
                    chk($sformatf("r%0d stage%0d data", r, i),
                        128'(stage_data[i*W +: W]), 128'(tbl[r].e_sd[i*W +: W]));
            end
        end

        // Backpressure: fill with the consumer stalled, hold 5 cycles, release.
        reset = 1'b0; stall = '0; flush = '0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(k);
            @(negedge clk);
            chk($sformatf("bp fill%0d in_ready", k), 128'(in_ready), 128'(1'b1));
            @(posedge clk);
            #1;
        end
        in_data = 32'hF6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d in_ready", k), 128'(in_ready), 128'(1'b0));
            chk($sformatf("bp hold%0d out_data", k), 128'(out_data), 128'(32'h100));
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d occupancy", k), 128'(occupancy), 128'(3'd4));
            chk($sformatf("bp hold%0d stage_data", k), 128'(stage_data),
                128'(sd(32'h100, 32'h101, 32'h102, 32'h103)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_data);
            @(posedge clk);
            #1;
        end
        chk("bp drained count", 128'(got.size()), 128'(4));
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("bp order%0d", k), 128'(got[k]), 128'(32'h100 + 32'(k)));
        chk("bp final occupancy", 128'(occupancy), 128'(3'd0));

        // Reset in the middle of a stream.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h51 + 32'(k);
            @(posedge clk);
            #1;
        end
        chk("rst pre occupancy", 128'(occupancy), 128'(3'd3));
        reset    = 1'b1;
        in_data  = 32'h54;
        @(negedge clk);
        chk("rst in_ready", 128'(in_ready), 128'(1'b0));
        chk("rst out_valid", 128'(out_valid), 128'(1'b0));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst occupancy", 128'(occupancy), 128'(3'd0));
        chk("rst stage_valid", 128'(stage_valid), 128'(4'b0));
        chk("rst stage_data", 128'(stage_data), 128'(0));
        @(negedge clk);
        chk("rst after out_valid", 128'(out_valid), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
